zero_detect_scheduler: RTL and testbench
========================================

Name: zero_detect_scheduler

Overview:
- Time-shares one serial Mealy zero detector among N_REQ requesters.
- Each requester presents a WIDTH-bit word. A round-robin arbiter grants one word, which is cleared into the detector and shifted in MSB-first.
- The block counts detector output pulses and reports the count with the requester ID.
- Sits between word-parallel client logic and the shared bit-serial detector.

Parameters:
- N_REQ, 4, number of requesters
- ID_W, 2, requester ID width; must equal clog2(N_REQ)
- WIDTH, 8, bits per word
- CNT_W, 4, result count width; must be at least clog2(WIDTH+1)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  N_REQ  request per requester; held with data until ack
- req_data  in  N_REQ*WIDTH  word for requester i at bits [i*WIDTH +: WIDTH]
- ack  out  N_REQ  one-cycle pulse; requester's word has been captured
- det_clear  out  1  sync clear to shared detector
- det_x_in  out  1  serial bit to detector
- det_y_out  in  1  detector Mealy output, combinational in det_x_in
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle result strobe
- done_id  out  ID_W  requester served; valid with done
- done_count  out  CNT_W  number of counted det_y_out pulses; valid with done

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, last_grant=N_REQ-1.
  - ack, det_clear, det_x_in, busy, done, done_id, done_count all 0.
  - Shift register, bit counter and pulse counter are cleared.
  - Reset overrides every state.
- Outputs are decoded from registered state only. No input-to-output combinational path.
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from last_grant+1 (mod N_REQ).
  - At the edge: load its word into the shift register, set last_grant to the chosen index, clear the pulse counter, go to CLEAR.
  - With no req, stay in IDLE.
- CLEAR (1 cycle):
  - ack[granted]=1, all other ack bits 0.
  - det_clear=1, det_x_in=0.
  - Next state is SHIFT, bit counter=0.
- SHIFT (exactly WIDTH cycles):
  - det_x_in = shift register MSB.
  - Each edge: shift left, increment the bit counter, and increment the pulse counter if det_y_out=1 in that cycle.
  - After the WIDTH-th bit, go to REPORT.
- REPORT (1 cycle):
  - done=1; done_id=last_grant; done_count=pulse count including the final bit.
  - det_x_in=0. Next state is IDLE.
- det_y_out is ignored outside SHIFT.
- Timing:
  - done is asserted WIDTH+2 cycles after the capture edge.
  - Minimum spacing between consecutive captures is WIDTH+3 cycles (one IDLE cycle is mandatory).
  - done_id and done_count hold their values until the next REPORT.
- Requester rules:
  - A requester must hold req and its data stable until it sees ack.
  - A req dropped before grant is simply not considered.
  - A requester may hold req across ack to submit its next word, but it is re-granted only after every other requesting index has been served (round robin).
- Simultaneous requests: served in rotating order; no requester waits more than N_REQ grants.
- Reset mid-operation:
  - The transfer is aborted with no done.
  - A word whose ack was already issued is lost; the client must resubmit.
  - last_grant returns to N_REQ-1, so index 0 has priority first.
- Count never overflows because CNT_W is constrained by WIDTH.

Test Plan:
1. Power-up: reset high for 2 cycles, req=0 → busy, done, ack, det_clear and det_x_in all 0. Stay IDLE after release.
2. Single request: req=4'b0001, word0=8'b1011_0010, bench stub det_y_out=~det_x_in →
   - ack=4'b0001 and det_clear=1 in the same cycle.
   - det_x_in sequence 1,0,1,1,0,0,1,0.
   - done 10 cycles after the capture edge, with done_id=0 and done_count=4.
3. Round robin: req=4'b1111 held →
   - grants in order 0,1,2,3,0.
   - successive ack pulses exactly 11 cycles apart.
   - each done_id matches the corresponding grant.
4. Rotation skip: after serving index 2, present req=4'b0101 → index 0 is granted next; index 2 is granted after it.
5. Reset mid-SHIFT after the 3rd bit →
   - no done; busy=0 and det_x_in=0 the cycle after reset.
   - with req=4'b1010 held, index 1 is granted first after release.
6. Count bounds:
   - det_y_out stuck 1 → done_count=8.
   - det_y_out=1 only during IDLE/CLEAR/REPORT, 0 in SHIFT → done_count=0.

Source files
------------

// File: rtl/zero_detect_scheduler_if.sv
// Requester-side handshake and result bundle for zero_detect_scheduler.
interface zero_detect_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       done_count;

    modport master (
        output req, req_data,
        input  ack, done, done_id, done_count
    );

    modport slave (
        input  req, req_data,
        output ack, done, done_id, done_count
    );
endinterface

// File: rtl/zero_detect_scheduler.sv
// Round-robin time-sharing of one serial zero detector among word requesters;
// each granted word is shifted MSB-first and detector pulses are counted.
module zero_detect_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clock,
    input  logic reset,
    zero_detect_scheduler_if.slave bus,
    output logic det_clear,
    output logic det_x_in,
    input  logic det_y_out,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t            state, state_nx;
    logic [ID_W-1:0]   last_grant, pick;
    logic              any_req;
    logic [WIDTH-1:0]  sreg;
    logic [BW-1:0]     bcnt;
    logic [CNT_W-1:0]  pcnt, pcnt_inc;
    logic              last_bit;

    // Scan from highest offset down so the nearest index after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = last_grant;
        any_req = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (bus.req[idx]) begin
                pick    = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign pcnt_inc = pcnt + CNT_W'(det_y_out);
    assign last_bit = (bcnt == LAST_BIT);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        det_clear = 1'b0;
        det_x_in  = 1'b0;
        bus.done  = 1'b0;
        bus.ack   = '0;
        unique case (state)
            IDLE: begin
                if (any_req) state_nx = CLEAR;
            end
            CLEAR: begin
                det_clear            = 1'b1;
                bus.ack[last_grant]  = 1'b1;
                state_nx             = SHIFT;
            end
            SHIFT: begin
                det_x_in = sreg[WIDTH-1];
                if (last_bit) state_nx = REPORT;
            end
            REPORT: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers load on the final shift so they hold until the next report.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant     <= ID_W'(N_REQ - 1);
            sreg           <= '0;
            bcnt           <= '0;
            pcnt           <= '0;
            bus.done_id    <= '0;
            bus.done_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= pick;
                        sreg       <= bus.req_data[int'(pick)*WIDTH +: WIDTH];
                        pcnt       <= '0;
                    end
                end
                CLEAR: begin
                    bcnt <= '0;
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    bcnt <= bcnt + BW'(1);
                    pcnt <= pcnt_inc;
                    if (last_bit) begin
                        bus.done_id    <= last_grant;
                        bus.done_count <= pcnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_zero_detect_scheduler.sv
// Bench for zero_detect_scheduler: transaction-level model checked every
// cycle, directed scenarios pinned with literal expectations, then random.
module tb_zero_detect_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic det_clear, det_x_in, det_y_out, busy;
    int   y_mode  = 0;
    logic rnd_bit = 1'b0;

    zero_detect_scheduler_if #(
        .N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .CNT_W(CNT_W)
    ) bus ();

    zero_detect_scheduler #(
        .N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .det_clear(det_clear),
        .det_x_in(det_x_in),
        .det_y_out(det_y_out),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Detector stub: 0 zero-detector, 1 stuck high, 2 high outside shifting, 3 random.
    assign det_y_out = (y_mode == 0) ? ~det_x_in :
                       (y_mode == 1) ? 1'b1 :
                       (y_mode == 2) ? (det_clear | ~busy | bus.done) :
                       rnd_bit;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [N_REQ-1:0] hold = '0;
    logic [N_REQ-1:0] ack_last = '0;
    int ack_id[$], ack_t[$], done_t[$], done_idq[$], done_cntq[$];
    logic [WIDTH-1:0] xsh = '0;

    // Model: p = -1 idle, 0 clear, 1..WIDTH bit p-1 on the wire, WIDTH+1 report.
    int p = -1;
    int m_last = N_REQ - 1;
    int m_id = 0, m_cnt = 0, h_id = 0, h_cnt = 0;
    logic [WIDTH-1:0] m_word = '0;
    bit m_valid = 1'b0;
    logic [N_REQ-1:0] e_ack;
    logic e_clr, e_x, e_busy, e_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always @(negedge clock) begin
        bit found;
        int idx;
        cyc++;
        if (m_valid) begin
            e_ack  = '0;
            e_clr  = (p == 0);
            e_x    = 1'b0;
            e_busy = (p >= 0);
            e_done = (p == WIDTH + 1);
            if (p == 0) e_ack[m_id] = 1'b1;
            if (p >= 1 && p <= WIDTH) e_x = m_word[WIDTH-p];
            check("ack", bus.ack, e_ack);
            check("det_clear", det_clear, e_clr);
            check("det_x_in", det_x_in, e_x);
            check("busy", busy, e_busy);
            check("done", bus.done, e_done);
            check("done_id", bus.done_id, h_id);
            check("done_count", bus.done_count, h_cnt);
            if (bus.ack != '0) begin
                for (int i = 0; i < N_REQ; i++)
                    if (bus.ack[i]) ack_id.push_back(i);
                ack_t.push_back(cyc);
            end
            if (bus.done) begin
                done_t.push_back(cyc);
                done_idq.push_back(int'(bus.done_id));
                done_cntq.push_back(int'(bus.done_count));
            end
            if (busy && !det_clear && !bus.done) xsh = {xsh[WIDTH-2:0], det_x_in};
        end
        ack_last = bus.ack;
        if (reset) begin
            p = -1; m_last = N_REQ - 1; h_id = 0; h_cnt = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (p < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (m_last + k) % N_REQ;
                    if (!found && bus.req[idx]) begin
                        found  = 1'b1;
                        m_id   = idx;
                        m_last = idx;
                        m_word = bus.req_data[idx*WIDTH +: WIDTH];
                        m_cnt  = 0;
                        p      = 0;
                    end
                end
            end else if (p == 0) begin
                p = 1;
            end else if (p <= WIDTH) begin
                m_cnt += int'(det_y_out);
                if (p == WIDTH) begin
                    h_id  = m_id;
                    h_cnt = m_cnt;
                end
                p++;
            end else begin
                p = -1;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N_REQ; i++)
                if (ack_last[i] && !hold[i]) bus.req[i] = 1'b0;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input int n, input int bound);
        int t = 0;
        while (done_t.size() < n && t < bound) begin
            step();
            t++;
        end
        check("done_timeout", done_t.size() >= n, 1);
    endtask

    task automatic wait_ack(input int n, input int bound);
        int t = 0;
        while (ack_id.size() < n && t < bound) begin
            step();
            t++;
        end
        check("ack_timeout", ack_id.size() >= n, 1);
    endtask

    task automatic clear_logs();
        ack_id.delete(); ack_t.delete(); done_t.delete();
        done_idq.delete(); done_cntq.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        // Power-up
        reset = 1'b1;
        step(2);
        check("rst_busy", busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_clear", det_clear, 0);
        check("rst_x", det_x_in, 0);
        reset = 1'b0;
        step(3);
        check("idle_busy", busy, 0);

        // Single request through the zero-detector stub
        y_mode = 0;
        clear_logs();
        bus.req_data[WIDTH-1:0] = 8'b1011_0010;
        bus.req = 4'b0001;
        wait_done(1, 40);
        check("t2_ack_id", qget(ack_id, 0), 0);
        check("t2_xseq", xsh, 8'b1011_0010);
        check("t2_count", qget(done_cntq, 0), 4);
        check("t2_done_id", qget(done_idq, 0), 0);
        // Done lands in the 10th cycle after capture, i.e. 9 after the ack cycle.
        check("t2_latency", qget(done_t, 0) - qget(ack_t, 0), WIDTH + 1);
        step(2);

        // Round robin with all requesters holding
        pulse_reset();
        clear_logs();
        for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom);
        hold = 4'b1111;
        bus.req = 4'b1111;
        wait_ack(5, 80);
        hold = '0;
        bus.req = '0;
        wait_done(5, 40);
        for (int k = 0; k < 5; k++) check("t3_grant", qget(ack_id, k), k % N_REQ);
        for (int k = 0; k < 4; k++)
            check("t3_spacing", qget(ack_t, k + 1) - qget(ack_t, k), WIDTH + 3);
        for (int k = 0; k < 5; k++) check("t3_done_id", qget(done_idq, k), k % N_REQ);
        step(2);

        // Rotation skip after serving index 2
        clear_logs();
        bus.req = 4'b0100;
        wait_done(1, 40);
        step(2);
        bus.req = 4'b0101;
        wait_done(3, 60);
        check("t4_first", qget(ack_id, 0), 2);
        check("t4_second", qget(ack_id, 1), 0);
        check("t4_third", qget(ack_id, 2), 2);
        step(2);

        // Reset in the middle of shifting
        y_mode = 3;
        clear_logs();
        hold = 4'b0001;
        bus.req = 4'b0001;
        wait_ack(1, 40);
        step(3);
        reset = 1'b1;
        bus.req = 4'b1010;
        hold = 4'b1010;
        step();
        check("t5_busy", busy, 0);
        check("t5_x", det_x_in, 0);
        check("t5_done", bus.done, 0);
        reset = 1'b0;
        wait_ack(2, 40);
        check("t5_regrant", qget(ack_id, 1), 1);
        check("t5_no_done", done_t.size(), 0);
        hold = '0;
        wait_done(2, 60);
        step(3);

        // Count bounds
        bus.req = '0;
        pulse_reset();
        clear_logs();
        y_mode = 1;
        bus.req_data[WIDTH-1:0] = 8'($urandom);
        bus.req = 4'b0001;
        wait_done(1, 40);
        check("t6_stuck_one", qget(done_cntq, 0), WIDTH);
        step(2);
        y_mode = 2;
        bus.req = 4'b0001;
        wait_done(2, 40);
        check("t6_none", qget(done_cntq, 1), 0);
        step(2);

        // Random traffic with occasional resets
        y_mode = 3;
        clear_logs();
        hold = '0;
        repeat (3000) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                end else if (bus.req[i] && $urandom_range(0, 49) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            step();
        end
        reset = 1'b0;
        bus.req = '0;
        step(20);
        check("rand_activity", done_t.size() > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
